// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants
// for the data-memory access controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } dmem_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BM_B = 4'b0001;
  localparam logic [3:0] BM_H = 4'b0011;
  localparam logic [3:0] BM_W = 4'b1111;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: single-port data-memory bus.
// master = access controller, slave = memory.
interface dmem_access_ctrl_if;

  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [3:0]  mem_wmask_out;
  logic [31:0] mem_wdata_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;

  modport master (
    output mem_req_out,
    output mem_we_out,
    output mem_addr_out,
    output mem_wmask_out,
    output mem_wdata_out,
    input  mem_ack_in,
    input  mem_rdata_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_we_out,
    input  mem_addr_out,
    input  mem_wmask_out,
    input  mem_wdata_out,
    output mem_ack_in,
    output mem_rdata_in
  );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane mask/data shift for stores,
// extract and sign/zero extend for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  input  logic        is_unsigned,
  output logic [7:0]  mask,
  output logic [63:0] data,
  output logic [31:0] rdata
);

  logic [3:0]  base;
  logic [31:0] sh;
  logic [4:0]  bits;

  assign bits = {offset, 3'b000};

  // store side: base mask by size, then shift both to lane
  always_comb begin
    base = BM_W;
    unique case (1'b1)
      size == SZ_B: base = BM_B;
      size == SZ_H: base = BM_H;
      default:      base = BM_W;
    endcase
    mask = {4'b0000, base} << offset;
    data = {32'b0, wdata} << bits;
  end

  // load side: right-align buffer, truncate, extend
  always_comb begin
    sh = 32'(rbuf >> bits);
    rdata = sh;
    unique case (1'b1)
      size == SZ_B:
        rdata = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
      size == SZ_H:
        rdata = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
      default:
        rdata = sh;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences RV32I loads/stores onto the
// data-memory bus, splitting word-crossing accesses.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        acc_valid_in,
  output logic        acc_ready_out,
  input  logic        acc_we_in,
  input  logic [1:0]  acc_size_in,
  input  logic        acc_unsigned_in,
  input  logic [31:0] acc_addr_in,
  input  logic [31:0] acc_wdata_in,
  output logic        stall_out,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_err_out,
  dmem_access_ctrl_if.master mem
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  dmem_state_t state, nxt;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [63:0] rbuf_q;
  logic        err_q;
  logic [7:0]  cnt_q;

  logic [7:0]  mask;
  logic [63:0] data;
  logic [31:0] ext;
  logic        split;
  logic        accept;
  logic        beat;
  logic        hi;
  logic        ack;
  logic        tmo;
  logic        set_err;

  dmem_lane_align u_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .rbuf        (rbuf_q),
    .is_unsigned (uns_q),
    .mask        (mask),
    .data        (data),
    .rdata       (ext)
  );

  assign split  = |mask[7:4];
  assign accept = acc_valid_in & (state == IDLE);
  assign beat   = (state == BEAT0) | (state == BEAT1);
  assign hi     = (state == BEAT1);
  assign ack    = beat & mem.mem_ack_in;
  assign tmo    = (cnt_q == TMO_LAST);

  // next-state decode; timeout only counts when no ack
  always_comb begin
    nxt     = state;
    set_err = 1'b0;
    unique case (state)
      IDLE:
        if (acc_valid_in) nxt = BEAT0;
      BEAT0:
        if (ack) begin
          nxt = split ? BEAT1 : RESP;
        end else if (tmo) begin
          nxt     = RESP;
          set_err = 1'b1;
        end
      BEAT1:
        if (ack) begin
          nxt = RESP;
        end else if (tmo) begin
          nxt     = RESP;
          set_err = 1'b1;
        end
      RESP:
        nxt = IDLE;
    endcase
  end

  // state, wait counter, capture and load buffer
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state <= nxt;
      if (state != nxt) cnt_q <= '0;
      else if (beat) cnt_q <= cnt_q + 8'd1;
      if (accept) begin
        we_q    <= acc_we_in;
        size_q  <= acc_size_in;
        uns_q   <= acc_unsigned_in;
        addr_q  <= acc_addr_in;
        wdata_q <= acc_wdata_in;
        rbuf_q  <= '0;
        err_q   <= 1'b0;
      end
      if (ack && !hi) rbuf_q[31:0]  <= mem.mem_rdata_in;
      if (ack && hi)  rbuf_q[63:32] <= mem.mem_rdata_in;
      if (set_err) err_q <= 1'b1;
    end
  end

  assign mem.mem_req_out = beat;
  assign mem.mem_we_out  = beat & we_q;
  assign mem.mem_addr_out = beat ?
    ({addr_q[31:2], 2'b00} + (hi ? 32'd4 : 32'd0)) : 32'd0;
  assign mem.mem_wmask_out = (beat & we_q) ?
    (hi ? mask[7:4] : mask[3:0]) : 4'b0000;
  assign mem.mem_wdata_out = (beat & we_q) ?
    (hi ? data[63:32] : data[31:0]) : 32'd0;

  assign acc_ready_out  = (state == IDLE);
  assign stall_out      = ~acc_ready_out | (acc_valid_in & acc_ready_out);
  assign resp_valid_out = (state == RESP);
  assign resp_err_out   = (state == RESP) & err_q;
  assign resp_rdata_out = ((state == RESP) & ~err_q & ~we_q) ?
    ext : 32'd0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed checks of the data-memory
// access controller with hand-computed expectations.
module tb_dmem_access_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        acc_valid_in;
  logic        acc_ready_out;
  logic        acc_we_in;
  logic [1:0]  acc_size_in;
  logic        acc_unsigned_in;
  logic [31:0] acc_addr_in;
  logic [31:0] acc_wdata_in;
  logic        stall_out;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_err_out;

  int tests = 0;
  int fails = 0;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .acc_valid_in    (acc_valid_in),
    .acc_ready_out   (acc_ready_out),
    .acc_we_in       (acc_we_in),
    .acc_size_in     (acc_size_in),
    .acc_unsigned_in (acc_unsigned_in),
    .acc_addr_in     (acc_addr_in),
    .acc_wdata_in    (acc_wdata_in),
    .stall_out       (stall_out),
    .resp_valid_out  (resp_valid_out),
    .resp_rdata_out  (resp_rdata_out),
    .resp_err_out    (resp_err_out),
    .mem             (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic start(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] d);
    acc_valid_in    = 1'b1;
    acc_we_in       = we;
    acc_size_in     = sz;
    acc_unsigned_in = uns;
    acc_addr_in     = a;
    acc_wdata_in    = d;
    #1 chk1("stall_accept", stall_out, 1'b1);
    chk1("ready_accept", acc_ready_out, 1'b1);
    @(posedge clk_in);
    @(negedge clk_in);
    acc_valid_in = 1'b0;
  endtask

  task automatic beat(input logic [31:0] rd);
    bus.mem_ack_in   = 1'b1;
    bus.mem_rdata_in = rd;
    @(posedge clk_in);
    @(negedge clk_in);
    bus.mem_ack_in   = 1'b0;
    bus.mem_rdata_in = '0;
  endtask

  task automatic idle_cycle;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    reset_in         = 1'b1;
    acc_valid_in     = 1'b0;
    acc_we_in        = 1'b0;
    acc_size_in      = 2'b00;
    acc_unsigned_in  = 1'b0;
    acc_addr_in      = '0;
    acc_wdata_in     = '0;
    bus.mem_ack_in   = 1'b0;
    bus.mem_rdata_in = '0;

    repeat (2) @(negedge clk_in);
    chk1("rst_ready", acc_ready_out, 1'b1);
    chk1("rst_req", bus.mem_req_out, 1'b0);
    chk1("rst_resp", resp_valid_out, 1'b0);
    chk1("rst_stall", stall_out, 1'b0);
    chk("rst_addr", bus.mem_addr_out, 32'h0);
    reset_in = 1'b0;
    idle_cycle();

    // stray ack while idle is ignored
    bus.mem_ack_in = 1'b1;
    idle_cycle();
    bus.mem_ack_in = 1'b0;
    chk1("stray_ready", acc_ready_out, 1'b1);
    chk1("stray_resp", resp_valid_out, 1'b0);

    // SW aligned, ack in first req cycle
    start(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    chk1("sw_req", bus.mem_req_out, 1'b1);
    chk1("sw_we", bus.mem_we_out, 1'b1);
    chk("sw_addr", bus.mem_addr_out, 32'h100);
    chk("sw_mask", 32'(bus.mem_wmask_out), 32'hF);
    chk("sw_data", bus.mem_wdata_out, 32'hDEADBEEF);
    chk1("sw_busy", acc_ready_out, 1'b0);
    chk1("sw_stall", stall_out, 1'b1);
    chk1("sw_noresp", resp_valid_out, 1'b0);
    beat(32'h0);
    chk1("sw_resp", resp_valid_out, 1'b1);
    chk1("sw_err", resp_err_out, 1'b0);
    chk("sw_rdata", resp_rdata_out, 32'h0);
    chk1("sw_req_off", bus.mem_req_out, 1'b0);
    chk1("sw_stall_resp", stall_out, 1'b1);
    idle_cycle();
    chk1("sw_ready_back", acc_ready_out, 1'b1);
    chk1("sw_resp_off", resp_valid_out, 1'b0);

    // SB lane 3
    start(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5);
    chk("sb_addr", bus.mem_addr_out, 32'h100);
    chk("sb_mask", 32'(bus.mem_wmask_out), 32'h8);
    chk("sb_data", bus.mem_wdata_out, 32'hA5000000);
    chk1("sb_we", bus.mem_we_out, 1'b1);
    beat(32'h0);
    chk1("sb_resp", resp_valid_out, 1'b1);
    idle_cycle();

    // LW split at 0x102
    start(1'b0, 2'b10, 1'b0, 32'h102, 32'hFFFFFFFF);
    chk("lw_a0", bus.mem_addr_out, 32'h100);
    chk("lw_m0", 32'(bus.mem_wmask_out), 32'h0);
    chk("lw_d0", bus.mem_wdata_out, 32'h0);
    chk1("lw_we", bus.mem_we_out, 1'b0);
    beat(32'h44332211);
    chk1("lw_req1", bus.mem_req_out, 1'b1);
    chk("lw_a1", bus.mem_addr_out, 32'h104);
    chk("lw_m1", 32'(bus.mem_wmask_out), 32'h0);
    chk1("lw_noresp", resp_valid_out, 1'b0);
    beat(32'h88776655);
    chk1("lw_resp", resp_valid_out, 1'b1);
    chk("lw_rdata", resp_rdata_out, 32'h66554433);
    idle_cycle();

    // LH split at 0x103
    start(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);
    beat(32'h12345678);
    chk("lh_a1", bus.mem_addr_out, 32'h104);
    beat(32'h000000FE);
    chk1("lh_resp", resp_valid_out, 1'b1);
    chk("lh_rdata", resp_rdata_out, 32'hFFFFFE12);
    idle_cycle();

    // LHU split at 0x103
    start(1'b0, 2'b01, 1'b1, 32'h103, 32'h0);
    beat(32'h12345678);
    beat(32'h000000FE);
    chk("lhu_rdata", resp_rdata_out, 32'h0000FE12);
    idle_cycle();

    // LB signed, unsplit lane 1
    start(1'b0, 2'b00, 1'b0, 32'h201, 32'h0);
    beat(32'h1122B344);
    chk1("lb_resp", resp_valid_out, 1'b1);
    chk("lb_rdata", resp_rdata_out, 32'hFFFFFFB3);
    idle_cycle();

    // SW with no ack: timeout after 4 req cycles
    start(1'b1, 2'b10, 1'b0, 32'h200, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      chk1("to_req", bus.mem_req_out, 1'b1);
      chk1("to_noresp", resp_valid_out, 1'b0);
      idle_cycle();
    end
    chk1("to_req_off", bus.mem_req_out, 1'b0);
    chk1("to_resp", resp_valid_out, 1'b1);
    chk1("to_err", resp_err_out, 1'b1);
    chk("to_rdata", resp_rdata_out, 32'h0);
    idle_cycle();
    chk1("to_ready", acc_ready_out, 1'b1);

    // LW wrapping past the top of memory
    start(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
    chk("wr_a0", bus.mem_addr_out, 32'hFFFFFFFC);
    beat(32'hAABBCCDD);
    chk("wr_a1", bus.mem_addr_out, 32'h00000000);
    beat(32'h11223344);
    chk1("wr_err", resp_err_out, 1'b0);
    chk("wr_rdata", resp_rdata_out, 32'h3344AABB);
    idle_cycle();

    // split SW at 0x301, reset during second beat
    start(1'b1, 2'b10, 1'b0, 32'h301, 32'hCAFEF00D);
    chk("rs_m0", 32'(bus.mem_wmask_out), 32'hE);
    chk("rs_d0", bus.mem_wdata_out, 32'hFEF00D00);
    beat(32'h0);
    chk1("rs_req1", bus.mem_req_out, 1'b1);
    chk("rs_a1", bus.mem_addr_out, 32'h304);
    chk("rs_m1", 32'(bus.mem_wmask_out), 32'h1);
    chk("rs_d1", bus.mem_wdata_out, 32'h000000CA);
    #1 reset_in = 1'b1;
    #1 chk1("rs_req_drop", bus.mem_req_out, 1'b0);
    chk1("rs_noresp", resp_valid_out, 1'b0);
    idle_cycle();
    chk1("rs_noresp2", resp_valid_out, 1'b0);
    reset_in = 1'b0;
    idle_cycle();
    chk1("rs_ready", acc_ready_out, 1'b1);
    chk1("rs_noresp3", resp_valid_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
